board_store: RTL and testbench
==============================

// Module: board_store
// PURPOSE
//  Parametrised board-state store for the game datapath. Holds ROWS*COLS piece codes.
//  Fills itself with the start position after reset or on request.
//  Commits atomic two-square moves through a valid/ready handshake and keeps an undo history.
//  Serves RD_PORTS combinational read ports to game logic and the VGA renderer.
// PARAMETERS
//  ROWS        8   board rows
//  COLS        8   board columns
//  PIECE_W     4   piece code width: {colour, type[2:0]}
//  RD_PORTS    2   number of independent read ports
//  UNDO_DEPTH  8   undo records kept; oldest is discarded when full
//  ADDR_W      6   derived: $clog2(ROWS*COLS); address = {row, col}
// PORTS
//  CLK         in   1                  single clock (game-logic clock domain)
//  RESET       in   1                  asynchronous, active-low reset
//  init_req    in   1                  pulse: restart the start-position fill
//  mv_valid    in   1                  move request valid
//  mv_ready    out  1                  move request accepted when valid&&ready
//  mv_src      in   ADDR_W             move source square
//  mv_dst      in   ADDR_W             move destination square
//  mv_piece    in   PIECE_W            code written to dst (allows promotion)
//  undo_req    in   1                  pulse: revert the last committed move
//  wr_en       in   1                  direct single-cell write (editor/debug)
//  wr_addr     in   ADDR_W             direct write address
//  wr_data     in   PIECE_W            direct write data
//  rd_addr     in   RD_PORTS*ADDR_W    packed read addresses; port p = [p*ADDR_W +: ADDR_W]
//  rd_data     out  RD_PORTS*PIECE_W   packed combinational read data
//  busy        out  1                  fill sweep in progress
//  undo_count  out  $clog2(UNDO_DEPTH+1)  valid undo records
//  move_count  out  16                 committed moves minus undone moves; bit0 = side to move
//  undo_err    out  1                  1-cycle pulse: undo requested with empty history
//  wr_drop     out  1                  1-cycle pulse: direct write ignored
// BEHAVIOUR
//  Reset (RESET low):
//   - state=INIT, fill_addr=0, busy=1, mv_ready=0.
//   - undo_count=0, move_count=0, undo_err=0, wr_drop=0.
//   - Cells are not reset. Their contents are defined only once busy falls.
//  FSM states: INIT, IDLE, COMMIT, UNDO.
//  INIT:
//   - Each cycle writes cell[fill_addr]=init_piece(fill_addr), then fill_addr++.
//   - After the write to address ROWS*COLS-1, go to IDLE. busy falls on the next edge.
//   - Fill takes ROWS*COLS cycles.
//   - For 8x8: rank 0 = black back rank, rank 1 = black pawns, ranks 6/7 = white. Other cells = 0.
//   - For any other ROWS/COLS, every cell fills with 0.
//  IDLE priority, highest first:
//   1. init_req: clear history, go to INIT with fill_addr=0.
//   2. undo_req: go to UNDO if undo_count>0. Otherwise pulse undo_err and stay in IDLE.
//   3. mv_valid: accept the move, go to COMMIT.
//   4. wr_en: write the cell and clear history (undo_count=0); move_count is unchanged.
//  mv_ready = (state==IDLE) && !init_req && !undo_req.
//  Acceptance latches src, dst and piece. The requester may drop mv_valid after acceptance.
//  COMMIT (1 cycle):
//   - Push {src, dst, cell[src], cell[dst]} onto the history, then cell[src]=0 and cell[dst]=mv_piece.
//   - If src==dst, the dst write wins.
//   - move_count++ (wraps mod 2^16). undo_count++ saturates at UNDO_DEPTH; when full, the oldest record is overwritten.
//   - Returns to IDLE. A back-to-back move is accepted 2 cycles after the previous one.
//  UNDO (1 cycle):
//   - Pop the newest record. Restore cell[dst]=dst_old, then cell[src]=src_old, so src_old wins when src==dst.
//   - undo_count--, move_count-- (wraps). Return to IDLE.
//  wr_drop pulses when wr_en is high and the write is not performed: state!=IDLE, or a higher-priority request in the same cycle.
//  undo_req and init_req outside IDLE are ignored silently.
//  Reads:
//   - rd_data is combinational from the cells. A write becomes visible the cycle after its edge.
//   - Out-of-range rd_addr (non-8x8 sizes) returns 0.
//  Reset mid-operation:
//   - Async return to INIT. The fill restarts at address 0 and a full ROWS*COLS cycles follow the release.
//   - An in-flight COMMIT or UNDO is abandoned.
// STRUCTURE
//  chess_pkg: PIECE_* and COLOR_* codes, PIECE_W, init_piece(addr) function, undo record typedef.
//  board_undo_stack: circular LIFO of UNDO_DEPTH records. Ports push, pop, clear, count, top.
//   - Push when full overwrites the oldest record. Pop when empty is blocked by the parent.
//  board_store: cell array, FSM, counters, read muxes.
// TESTING
//  1. Release RESET -> busy high 64 cycles, then low. rd 0=4'b1100, rd 4=4'b1110, rd 63=4'b0100, rd 52=4'b0001, rd 36=0.
//  2. Move 52->36, piece 4'b0001 -> next cycle rd36=0001, rd52=0000. move_count=1, undo_count=1, mv_ready low 1 cycle.
//  3. Undo after test 2 -> rd52=0001, rd36=0000, undo_count=0, move_count=0. A second undo -> undo_err one cycle, cells unchanged.
//  4. Nine distinct moves (UNDO_DEPTH=8) -> undo_count=8. Eight undos restore the board to its state after move 1; a ninth undo -> undo_err.
//  5. mv_valid and wr_en in the same IDLE cycle -> move committed, wr_drop pulses, cell at wr_addr unchanged. Later wr_en alone -> cell written, undo_count=0.
//  6. RESET low while fill_addr=20 -> busy stays high. After release, 64 fill cycles occur and test-1 values hold. mv_ready stays 0 throughout.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg: shared piece encodings, FSM state type, undo record layout and
// the start-position generator used by board_store.
//   Piece code = {colour, type[2:0]}; colour 1 = black, 0 = white.
package chess_pkg;

    localparam int PIECE_W = 4;

    localparam logic       COLOR_WHITE = 1'b0;
    localparam logic       COLOR_BLACK = 1'b1;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    // Record addresses cover boards of up to 64 cells.
    localparam int REC_ADDR_W = 6;

    typedef logic [PIECE_W-1:0] piece_t;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_UNDO   = 2'd3
    } state_t;

    typedef struct packed {
        logic [REC_ADDR_W-1:0] src;
        logic [REC_ADDR_W-1:0] dst;
        piece_t                src_old;
        piece_t                dst_old;
    } undo_rec_t;

    // Start position for a standard 8x8 board; any other geometry is empty.
    function automatic piece_t init_piece(input int unsigned addr,
                                          input int unsigned rows,
                                          input int unsigned cols);
        int unsigned row;
        int unsigned col;
        logic [2:0]  kind;
        piece_t      p;
        p = '0;
        if (rows == 8 && cols == 8 && addr < 64) begin
            row = addr / 8;
            col = addr % 8;
            case (col)
                0, 7:    kind = PIECE_ROOK;
                1, 6:    kind = PIECE_KNIGHT;
                2, 5:    kind = PIECE_BISHOP;
                3:       kind = PIECE_QUEEN;
                default: kind = PIECE_KING;
            endcase
            case (row)
                0:       p = {COLOR_BLACK, kind};
                1:       p = {COLOR_BLACK, PIECE_PAWN};
                6:       p = {COLOR_WHITE, PIECE_PAWN};
                7:       p = {COLOR_WHITE, kind};
                default: p = {COLOR_WHITE, PIECE_NONE};
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/board_undo_stack.sv
// board_undo_stack: circular LIFO of move records.
//   CLK       in   clock
//   RESET     in   asynchronous active-low reset
//   push      in   store push_rec as newest; overwrites oldest when full
//   pop       in   discard newest (parent never pops when empty)
//   clear     in   drop all records
//   push_rec  in   record to store
//   count     out  number of valid records (saturates at DEPTH)
//   top       out  newest record
module board_undo_stack #(
    parameter  int DEPTH = 8,
    parameter  int REC_W = 20,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [REC_W-1:0] push_rec,
    output logic [CNT_W-1:0] count,
    output logic [REC_W-1:0] top
);

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
    endfunction

    assign top = mem[ptr_dec(wr_ptr)];

    // Saturating count with a free-running write pointer: once full, the
    // next push lands on the oldest slot, which is exactly the one to drop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            count  <= '0;
        end else if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (count != CNT_W'(DEPTH))
                count <= count + 1'b1;
        end else if (pop) begin
            wr_ptr <= ptr_dec(wr_ptr);
            count  <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !clear)
            mem[wr_ptr] <= push_rec;
    end

endmodule

// File: rtl/board_store.sv
// board_store: board-state store with start-position fill, atomic two-square
// moves, undo history and combinational read ports.
//   CLK, RESET              clock, asynchronous active-low reset
//   init_req                restart the start-position fill (IDLE only)
//   mv_valid/mv_ready       move handshake; mv_src, mv_dst, mv_piece latched
//   undo_req                revert newest committed move (IDLE only)
//   wr_en/wr_addr/wr_data   direct single-cell write, clears history
//   rd_addr/rd_data         RD_PORTS packed combinational read ports
//   busy                    fill sweep in progress
//   undo_count, move_count  history depth, net committed moves
//   undo_err, wr_drop       1-cycle pulses for rejected undo / dropped write
module board_store #(
    parameter  int ROWS       = 8,
    parameter  int COLS       = 8,
    parameter  int PIECE_W    = 4,
    parameter  int RD_PORTS   = 2,
    parameter  int UNDO_DEPTH = 8,
    localparam int ADDR_W     = $clog2(ROWS * COLS),
    localparam int UC_W       = $clog2(UNDO_DEPTH + 1)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         init_req,
    input  logic                         mv_valid,
    output logic                         mv_ready,
    input  logic [ADDR_W-1:0]            mv_src,
    input  logic [ADDR_W-1:0]            mv_dst,
    input  logic [PIECE_W-1:0]           mv_piece,
    input  logic                         undo_req,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [PIECE_W-1:0]           wr_data,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*PIECE_W-1:0]  rd_data,
    output logic                         busy,
    output logic [UC_W-1:0]              undo_count,
    output logic [15:0]                  move_count,
    output logic                         undo_err,
    output logic                         wr_drop
);

    import chess_pkg::*;

    localparam int unsigned NCELLS = ROWS * COLS;
    localparam int unsigned NALLOC = 2 ** ADDR_W;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  fill_addr;
    logic [PIECE_W-1:0] cells [NALLOC];
    logic [ADDR_W-1:0]  lat_src, lat_dst;
    logic [PIECE_W-1:0] lat_piece;

    logic               accept, do_wr, fill_last;
    logic               hist_push, hist_pop, hist_clear;
    logic               undo_err_nx, wr_drop_nx;
    undo_rec_t          push_rec, top_rec;
    logic [$bits(undo_rec_t)-1:0] top_bits;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NCELLS;
    endfunction

    assign busy      = (state == ST_INIT);
    assign mv_ready  = (state == ST_IDLE) && !init_req && !undo_req;
    assign accept    = mv_ready && mv_valid;
    assign fill_last = (fill_addr == ADDR_W'(NCELLS - 1));
    assign top_rec   = undo_rec_t'(top_bits);

    always_comb begin
        push_rec.src     = REC_ADDR_W'(lat_src);
        push_rec.dst     = REC_ADDR_W'(lat_dst);
        push_rec.src_old = cells[lat_src];
        push_rec.dst_old = cells[lat_dst];
    end

    always_comb begin
        state_nx    = state;
        do_wr       = 1'b0;
        hist_push   = 1'b0;
        hist_pop    = 1'b0;
        hist_clear  = 1'b0;
        undo_err_nx = 1'b0;
        case (state)
            ST_INIT: begin
                if (fill_last)
                    state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_nx   = ST_INIT;
                    hist_clear = 1'b1;
                end else if (undo_req) begin
                    if (undo_count != '0)
                        state_nx = ST_UNDO;
                    else
                        undo_err_nx = 1'b1;
                end else if (mv_valid) begin
                    state_nx = ST_COMMIT;
                end else if (wr_en) begin
                    do_wr      = 1'b1;
                    hist_clear = 1'b1;
                end
            end
            ST_COMMIT: begin
                hist_push = 1'b1;
                state_nx  = ST_IDLE;
            end
            ST_UNDO: begin
                hist_pop = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_INIT;
        endcase
        wr_drop_nx = wr_en && !do_wr;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_INIT;
            fill_addr  <= '0;
            move_count <= '0;
            undo_err   <= 1'b0;
            wr_drop    <= 1'b0;
            lat_src    <= '0;
            lat_dst    <= '0;
            lat_piece  <= '0;
        end else begin
            state    <= state_nx;
            undo_err <= undo_err_nx;
            wr_drop  <= wr_drop_nx;
            if (state == ST_INIT)
                fill_addr <= fill_last ? '0 : fill_addr + 1'b1;
            else if (state_nx == ST_INIT)
                fill_addr <= '0;
            if (accept) begin
                lat_src   <= mv_src;
                lat_dst   <= mv_dst;
                lat_piece <= mv_piece;
            end
            if (state == ST_COMMIT)
                move_count <= move_count + 16'd1;
            else if (state == ST_UNDO)
                move_count <= move_count - 16'd1;
        end
    end

    // Paired writes rely on NBA ordering: the later statement wins when the
    // two addresses coincide (dst on commit, src_old on undo).
    always_ff @(posedge CLK) begin
        case (state)
            ST_INIT: cells[fill_addr] <= init_piece(32'(fill_addr), ROWS, COLS);
            ST_IDLE: begin
                if (do_wr)
                    cells[wr_addr] <= wr_data;
            end
            ST_COMMIT: begin
                cells[lat_src] <= '0;
                cells[lat_dst] <= lat_piece;
            end
            ST_UNDO: begin
                cells[ADDR_W'(top_rec.dst)] <= top_rec.dst_old;
                cells[ADDR_W'(top_rec.src)] <= top_rec.src_old;
            end
            default: ;
        endcase
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*PIECE_W +: PIECE_W] = in_range(a) ? cells[a] : '0;
    end

    board_undo_stack #(
        .DEPTH (UNDO_DEPTH),
        .REC_W ($bits(undo_rec_t))
    ) u_hist (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (hist_push),
        .pop      (hist_pop),
        .clear    (hist_clear),
        .push_rec (push_rec),
        .count    (undo_count),
        .top      (top_bits)
    );

endmodule

// File: tb/tb_board_store.sv
module tb_board_store;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        init_req = 1'b0;
    logic        mv_valid = 1'b0;
    logic        mv_ready;
    logic [5:0]  mv_src = '0;
    logic [5:0]  mv_dst = '0;
    logic [3:0]  mv_piece = '0;
    logic        undo_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [11:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        busy;
    logic [3:0]  undo_count;
    logic [15:0] move_count;
    logic        undo_err;
    logic        wr_drop;
    logic [3:0]  rd0, rd1;

    int total = 0;
    int bad = 0;

    assign rd0 = rd_data[3:0];
    assign rd1 = rd_data[7:4];

    board_store #(.ROWS(8), .COLS(8), .PIECE_W(4), .RD_PORTS(2), .UNDO_DEPTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .init_req(init_req), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_src(mv_src), .mv_dst(mv_dst), .mv_piece(mv_piece),
        .undo_req(undo_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .undo_count(undo_count),
        .move_count(move_count), .undo_err(undo_err), .wr_drop(wr_drop)
    );

    always #5 CLK = ~CLK;

    task automatic rd2(input logic [5:0] a0, input logic [5:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic do_move(input logic [5:0] s, input logic [5:0] d, input logic [3:0] pc);
        @(negedge CLK);
        mv_valid = 1'b1; mv_src = s; mv_dst = d; mv_piece = pc;
        @(negedge CLK);
        mv_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_undo();
        @(negedge CLK);
        undo_req = 1'b1;
        @(negedge CLK);
        undo_req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_start_position(input string tag);
        logic [5:0] a [5] = '{6'd0, 6'd4, 6'd63, 6'd52, 6'd36};
        logic [3:0] e [5] = '{4'b1100, 4'b1110, 4'b0100, 4'b0001, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            rd2(a[i], a[(i + 1) % 5]);
            total++;
            if (rd0 !== e[i] || rd1 !== e[(i + 1) % 5]) begin
                bad++;
                $display("FAIL %s_rd addr=%0d/%0d got=%b/%b exp=%b/%b", tag, a[i], a[(i + 1) % 5],
                         rd0, rd1, e[i], e[(i + 1) % 5]);
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge CLK); @(negedge CLK);
        total++;
        if (busy !== 1'b1 || mv_ready !== 1'b0) begin
            bad++; $display("FAIL reset_busy_ready got=%b/%b exp=1/0", busy, mv_ready);
        end
        total++;
        if (undo_count !== 4'd0 || move_count !== 16'd0 || undo_err !== 1'b0 || wr_drop !== 1'b0) begin
            bad++; $display("FAIL reset_counters got uc=%0d mc=%0d ue=%b wd=%b exp=0", undo_count,
                            move_count, undo_err, wr_drop);
        end
        RESET = 1'b1;
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (busy && cyc < 200);
        total++;
        if (cyc !== 64) begin bad++; $display("FAIL fill_cycles got=%0d exp=64", cyc); end
        test_start_position("init");
        total++;
        if (mv_ready !== 1'b1) begin bad++; $display("FAIL ready_after_fill got=%b exp=1", mv_ready); end
    endtask

    task automatic test_move();
        @(negedge CLK);
        mv_valid = 1'b1; mv_src = 6'd52; mv_dst = 6'd36; mv_piece = 4'b0001;
        #1;
        total++;
        if (mv_ready !== 1'b1) begin bad++; $display("FAIL move_ready got=%b exp=1", mv_ready); end
        @(negedge CLK);
        mv_valid = 1'b0;
        #1;
        total++;
        if (mv_ready !== 1'b0) begin bad++; $display("FAIL move_commit_ready got=%b exp=0", mv_ready); end
        @(negedge CLK);
        rd2(6'd36, 6'd52);
        total++;
        if (rd0 !== 4'b0001 || rd1 !== 4'b0000) begin
            bad++; $display("FAIL move_cells got=%b/%b exp=0001/0000", rd0, rd1);
        end
        total++;
        if (move_count !== 16'd1 || undo_count !== 4'd1 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL move_counts got mc=%0d uc=%0d rdy=%b exp 1/1/1", move_count, undo_count, mv_ready);
        end
    endtask

    task automatic test_undo();
        @(negedge CLK);
        undo_req = 1'b1;
        @(negedge CLK);
        undo_req = 1'b0;
        #1;
        total++;
        if (mv_ready !== 1'b0) begin bad++; $display("FAIL undo_state_ready got=%b exp=0", mv_ready); end
        @(negedge CLK);
        rd2(6'd52, 6'd36);
        total++;
        if (rd0 !== 4'b0001 || rd1 !== 4'b0000 || undo_count !== 4'd0 || move_count !== 16'd0) begin
            bad++; $display("FAIL undo_restore got=%b/%b uc=%0d mc=%0d exp=0001/0000/0/0", rd0, rd1,
                            undo_count, move_count);
        end
        undo_req = 1'b1;
        @(negedge CLK);
        undo_req = 1'b0;
        #1;
        total++;
        if (undo_err !== 1'b1) begin bad++; $display("FAIL undo_err_pulse got=%b exp=1", undo_err); end
        @(negedge CLK);
        rd2(6'd52, 6'd36);
        total++;
        if (undo_err !== 1'b0 || rd0 !== 4'b0001 || rd1 !== 4'b0000 || move_count !== 16'd0) begin
            bad++; $display("FAIL undo_err_after got=%b %b/%b mc=%0d exp=0 0001/0000 0", undo_err, rd0, rd1, move_count);
        end
    endtask

    task automatic test_depth();
        logic [3:0] exp;
        for (int i = 0; i < 8; i++) do_move(6'(48 + i), 6'(40 + i), 4'b0001);
        do_move(6'd56, 6'd32, 4'b0100);
        rd2(6'd32, 6'd56);
        total++;
        if (undo_count !== 4'd8 || move_count !== 16'd9 || rd0 !== 4'b0100 || rd1 !== 4'b0000) begin
            bad++; $display("FAIL depth_full got uc=%0d mc=%0d %b/%b exp 8/9 0100/0000", undo_count, move_count, rd0, rd1);
        end
        for (int i = 0; i < 8; i++) do_undo();
        total++;
        if (undo_count !== 4'd0 || move_count !== 16'd1) begin
            bad++; $display("FAIL depth_unwound got uc=%0d mc=%0d exp 0/1", undo_count, move_count);
        end
        for (int a = 40; a <= 56; a++) begin
            exp = (a == 40) ? 4'b0001 : (a < 48) ? 4'b0000 : (a == 48) ? 4'b0000 :
                  (a < 56) ? 4'b0001 : 4'b0100;
            rd2(6'(a), 6'd32);
            total++;
            if (rd0 !== exp || rd1 !== 4'b0000) begin
                bad++; $display("FAIL depth_cell%0d got=%b/%b exp=%b/0000", a, rd0, rd1, exp);
            end
        end
        @(negedge CLK);
        undo_req = 1'b1;
        @(negedge CLK);
        undo_req = 1'b0;
        #1;
        total++;
        if (undo_err !== 1'b1 || move_count !== 16'd1) begin
            bad++; $display("FAIL depth_undo_err got=%b mc=%0d exp=1/1", undo_err, move_count);
        end
    endtask

    task automatic test_conflict();
        @(negedge CLK);
        mv_valid = 1'b1; mv_src = 6'd49; mv_dst = 6'd41; mv_piece = 4'b0001;
        wr_en = 1'b1; wr_addr = 6'd20; wr_data = 4'b1010;
        @(negedge CLK);
        mv_valid = 1'b0; wr_en = 1'b0;
        #1;
        total++;
        if (wr_drop !== 1'b1) begin bad++; $display("FAIL conflict_drop got=%b exp=1", wr_drop); end
        @(negedge CLK);
        rd2(6'd20, 6'd41);
        total++;
        if (wr_drop !== 1'b0 || rd0 !== 4'b0000 || rd1 !== 4'b0001 || undo_count !== 4'd1 || move_count !== 16'd2) begin
            bad++; $display("FAIL conflict_state got wd=%b %b/%b uc=%0d mc=%0d exp 0 0000/0001 1 2", wr_drop, rd0, rd1,
                            undo_count, move_count);
        end
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 6'd20; wr_data = 4'b1010;
        @(negedge CLK);
        wr_en = 1'b0;
        rd2(6'd20, 6'd49);
        total++;
        if (wr_drop !== 1'b0 || rd0 !== 4'b1010 || rd1 !== 4'b0000 || undo_count !== 4'd0 || move_count !== 16'd2) begin
            bad++; $display("FAIL direct_write got wd=%b %b/%b uc=%0d mc=%0d exp 0 1010/0000 0 2", wr_drop, rd0, rd1,
                            undo_count, move_count);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        mv_valid = 1'b1; mv_src = 6'd50; mv_dst = 6'd42; mv_piece = 4'b0001;
        @(negedge CLK);
        mv_src = 6'd51; mv_dst = 6'd43;
        wr_en = 1'b1; wr_addr = 6'd21; wr_data = 4'b0111;
        #1;
        total++;
        if (mv_ready !== 1'b0) begin bad++; $display("FAIL b2b_commit_ready got=%b exp=0", mv_ready); end
        @(negedge CLK);
        wr_en = 1'b0;
        #1;
        total++;
        if (wr_drop !== 1'b1 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_idle got wd=%b rdy=%b exp 1/1", wr_drop, mv_ready);
        end
        @(negedge CLK);
        mv_valid = 1'b0;
        @(negedge CLK);
        rd2(6'd42, 6'd43);
        total++;
        if (rd0 !== 4'b0001 || rd1 !== 4'b0001) begin bad++; $display("FAIL b2b_dst got=%b/%b exp=0001/0001", rd0, rd1); end
        rd2(6'd50, 6'd51);
        total++;
        if (rd0 !== 4'b0000 || rd1 !== 4'b0000) begin bad++; $display("FAIL b2b_src got=%b/%b exp=0000/0000", rd0, rd1); end
        rd2(6'd21, 6'd41);
        total++;
        if (rd0 !== 4'b0000 || rd1 !== 4'b0001 || move_count !== 16'd4 || undo_count !== 4'd2) begin
            bad++; $display("FAIL b2b_misc got=%b/%b mc=%0d uc=%0d exp 0000/0001 4 2", rd0, rd1, move_count, undo_count);
        end
    endtask

    task automatic test_same_square();
        do_move(6'd20, 6'd20, 4'b0011);
        rd2(6'd20, 6'd21);
        total++;
        if (rd0 !== 4'b0011 || move_count !== 16'd5 || undo_count !== 4'd3) begin
            bad++; $display("FAIL same_sq_move got=%b mc=%0d uc=%0d exp 0011 5 3", rd0, move_count, undo_count);
        end
        do_undo();
        rd2(6'd20, 6'd21);
        total++;
        if (rd0 !== 4'b1010 || move_count !== 16'd4 || undo_count !== 4'd2) begin
            bad++; $display("FAIL same_sq_undo got=%b mc=%0d uc=%0d exp 1010 4 2", rd0, move_count, undo_count);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        int rdy_seen;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (20) @(negedge CLK);
        RESET = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || mv_ready !== 1'b0 || move_count !== 16'd0 || undo_count !== 4'd0) begin
            bad++; $display("FAIL midfill_reset got busy=%b rdy=%b mc=%0d uc=%0d exp 1 0 0 0", busy, mv_ready,
                            move_count, undo_count);
        end
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b1;
        cyc = 0;
        rdy_seen = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (busy && mv_ready) rdy_seen++;
        end while (busy && cyc < 200);
        total++;
        if (cyc !== 64 || rdy_seen !== 0) begin
            bad++; $display("FAIL midfill_cycles got=%0d ready_during_fill=%0d exp=64/0", cyc, rdy_seen);
        end
        test_start_position("refill");
        rd2(6'd20, 6'd40);
        total++;
        if (rd0 !== 4'b0000 || rd1 !== 4'b0000) begin
            bad++; $display("FAIL refill_cleared got=%b/%b exp=0000/0000", rd0, rd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_move();
        test_undo();
        test_depth();
        test_conflict();
        test_back_to_back();
        test_same_square();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
